// File: rtl/cpu_pkg.sv
// Shared CPU constants: reset/exception vectors, instruction-memory bounds, exception codes.
package cpu_pkg;

   localparam logic [31:0] PC_RESET  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] IM_LO     = 32'h0000_3000;
   localparam logic [31:0] IM_HI     = 32'h0000_6FFC;
   localparam logic [4:0]  EXC_ADEL  = 5'd4;
   localparam logic [4:0]  EXC_NONE  = 5'd0;

endpackage

// File: rtl/fd_reg.sv
// F/D pipeline register. A flush overrides the enable: it loads flush_pc_i and clears the rest.
module fd_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RST_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   input  logic [4:0]  exccode_i,
   input  logic        bd_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic [4:0]  exccode_o,
   output logic        bd_o
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [4:0]  exc_q, exc_d;
   logic        bd_q, bd_d;

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      exc_d   = exc_q;
      bd_d    = bd_q;
      if (flush_i) begin
         pc_d    = flush_pc_i;
         instr_d = '0;
         exc_d   = EXC_NONE;
         bd_d    = 1'b0;
      end else if (en_i) begin
         pc_d    = pc_i;
         instr_d = instr_i;
         exc_d   = exccode_i;
         bd_d    = bd_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q    <= RST_PC;
         instr_q <= '0;
         exc_q   <= EXC_NONE;
         bd_q    <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         exc_q   <= exc_d;
         bd_q    <= bd_d;
      end
   end

   assign pc_o      = pc_q;
   assign instr_o   = instr_q;
   assign exccode_o = exc_q;
   assign bd_o      = bd_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, AdEL check and F/D register control.
// Optional fetch counter output enabled with macro FETCH_PERF_CNT_EN.
module fetch_stage
   import cpu_pkg::IM_LO, cpu_pkg::IM_HI, cpu_pkg::EXC_ADEL, cpu_pkg::EXC_NONE;
#(
   parameter logic [31:0] PC_RESET  = cpu_pkg::PC_RESET,
   parameter logic [31:0] EXC_ENTRY = cpu_pkg::EXC_ENTRY
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        req,
   input  logic        D_eret,
   input  logic        D_is_bj,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] i_inst_addr,
   output logic [31:0] F_pc,
   output logic [31:0] D_pc,
   output logic [31:0] D_instr,
   output logic [4:0]  D_exccode,
   output logic        D_bd
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt
`endif
);

   logic [31:0] pc_q, pc_d;
   logic        f_adel;
   logic [31:0] f_instr;
   logic [4:0]  f_exccode;
   logic        fd_flush;
   logic [31:0] fd_flush_pc;

   assign f_adel    = (pc_q[1:0] != 2'b00) | (pc_q < IM_LO) | (pc_q > IM_HI);
   assign f_instr   = f_adel ? 32'h0 : i_inst_rdata;
   assign f_exccode = f_adel ? EXC_ADEL : EXC_NONE;

   // An eret under stall must not flush: the stall freezes D, eret retires later.
   assign fd_flush    = req | (D_eret & ~stall);
   assign fd_flush_pc = req ? EXC_ENTRY : pc_q;

   always_comb begin
      pc_d = pc_q;
      if (req || !stall) pc_d = npc;
   end

   always_ff @(posedge clk) begin
      if (!reset) pc_q <= PC_RESET;
      else        pc_q <= pc_d;
   end

   assign F_pc        = pc_q;
   assign i_inst_addr = pc_q;

   fd_reg #(.RST_PC(PC_RESET)) u_fd_reg (
      .clk        (clk),
      .reset      (reset),
      .en_i       (~stall),
      .flush_i    (fd_flush),
      .flush_pc_i (fd_flush_pc),
      .pc_i       (pc_q),
      .instr_i    (f_instr),
      .exccode_i  (f_exccode),
      .bd_i       (D_is_bj),
      .pc_o       (D_pc),
      .instr_o    (D_instr),
      .exccode_o  (D_exccode),
      .bd_o       (D_bd)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!req && !stall && !D_eret && !f_adel) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign fetch_cnt = cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, the PC value loaded at reset.
REQ-002 SHALL have parameter EXC_ENTRY, default 32'h0000_4180, the exception handler entry address.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous active-low reset.
REQ-005 SHALL have port npc, input, 32 bits, the next-PC from the D-stage next-PC logic.
REQ-006 SHALL have port stall, input, 1 bit, the hazard-unit freeze of F and D.
REQ-007 SHALL have port req, input, 1 bit, the CP0 exception/interrupt flush request.
REQ-008 SHALL have port D_eret, input, 1 bit, meaning an eret is in D.
REQ-009 SHALL have port D_is_bj, input, 1 bit, meaning D holds a branch/jump.
REQ-010 SHALL have port i_inst_rdata, input, 32 bits, the IM read data for i_inst_addr.
REQ-011 SHALL have port i_inst_addr, output, 32 bits, equal to F_pc.
REQ-012 SHALL have port F_pc, output, 32 bits, the current fetch PC.
REQ-013 SHALL have ports D_pc (32), D_instr (32), D_exccode (5) and D_bd (1), all outputs, forming the F/D pipeline register.

Function
REQ-014 SHALL compute F_adel = (F_pc[1:0]!=0) | (F_pc<32'h3000) | (F_pc>32'h6FFC) combinationally.
REQ-015 SHALL form F_instr = F_adel ? 32'h0 : i_inst_rdata, and F_exccode = F_adel ? 5'd4 : 5'd0.
REQ-016 SHALL form F_bd = D_is_bj.
REQ-017 SHALL apply the per-edge priority reset > req > stall > D_eret > normal.
REQ-018 SHALL, on req, load F_pc <= npc and load the F/D register with D_pc=EXC_ENTRY, D_instr=0, D_exccode=0, D_bd=0, regardless of stall.
REQ-019 SHALL, on stall without req, hold F_pc and every F/D field, even when D_eret=1.
REQ-020 SHALL, on D_eret without stall or req, load F_pc <= npc and clear the F/D register (D_pc=F_pc, others 0), giving eret no delay slot.
REQ-021 SHALL, in the normal case, load F_pc <= npc and F/D <= {F_pc, F_instr, F_exccode, F_bd}.
REQ-022 SHALL perform PC arithmetic modulo 2^32 with no saturation, and SHALL NOT self-correct a misaligned npc; it is flagged by REQ-014.
REQ-023 SHALL have one cycle of latency F->D, and all outputs SHALL be registered except i_inst_addr/F_pc, which are the register itself.

Reset
REQ-024 SHALL, while reset==0 at a clock edge, set F_pc=PC_RESET, D_pc=PC_RESET, D_instr=0, D_exccode=0, D_bd=0 (and the counter to 0 if present).
REQ-025 SHALL, when reset is asserted mid-stall or mid-flush, override stall, req and eret.

Configuration
REQ-026 SHALL, with macro FETCH_PERF_CNT_EN defined, add output fetch_cnt (32 bits), incremented on each normal-case edge (REQ-021) where F_adel==0, held otherwise, and wrapping at 2^32.
REQ-027 SHALL, with FETCH_PERF_CNT_EN undefined, omit fetch_cnt and its logic entirely.

Structure
REQ-028 SHALL place PC_RESET, EXC_ENTRY, IM bounds 32'h3000/32'h6FFC, EXC_ADEL=5'd4 and EXC_NONE=5'd0 in shared package cpu_pkg.
REQ-029 SHALL implement the F/D register as sub-module fd_reg with inputs en, flush and flush_pc; the PC register and AdEL check SHALL stay in fetch_stage.

Verification
REQ-030 SHALL verify: reset low 2 cycles then high with npc=F_pc+4 -> F_pc 0x3000, 0x3004, 0x3008, and D_pc trails by one cycle.
REQ-031 SHALL verify: stall=1 for 3 cycles at F_pc=0x3010 -> F_pc and D_* hold; on release F_pc=npc.
REQ-032 SHALL verify: req=1 with stall=1 and npc=0x4180 -> next F_pc=0x4180, D_pc=0x4180, D_instr=0.
REQ-033 SHALL verify: npc=0x3002 -> next cycle D is empty, then D_instr=0 and D_exccode=4 one cycle later; likewise F_pc=0x7000.
REQ-034 SHALL verify: D_eret=1, npc=EPC=0x3020 -> F_pc=0x3020 and D_instr=0 next cycle; with stall=1 at the same time, everything holds.
REQ-035 SHALL verify, with FETCH_PERF_CNT_EN: 5 normal fetches, 1 stall, 1 AdEL -> fetch_cnt=5.
